// File: rtl/uart_message_streamer.sv
// Streams a runtime-programmable message from an internal buffer to a UART
// transmitter over a valid/ready handshake, with one-shot/repeat, abort and status.
module uart_message_streamer #(
  parameter int DEPTH  = 16,
  parameter int DATA_W = 8,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W:0]   msg_len,
  input  logic              start,
  input  logic              repeat_en,
  input  logic              abort,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] char_index
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    SEND  = 2'd2
  } state_t;

  localparam logic [ADDR_W:0]   DEPTH_L  = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   LEN_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] IDX_ONE  = ADDR_W'(1);

  state_t              state_q, state_d;
  logic [ADDR_W:0]     len_q, len_d;
  logic [ADDR_W-1:0]   char_index_q, char_index_d;
  logic                done_q, done_d;
  logic [DATA_W-1:0]   tx_data_q;
  logic                last_char;

  logic [DATA_W-1:0]   mem [DEPTH];

  // Buffer has no reset so it can map onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_en && ({1'b0, wr_addr} < DEPTH_L)) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Registered read doubles as the output holding register; it only loads in
  // FETCH, which keeps tx_data stable for the whole SEND stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_data_q <= '0;
    end else if (state_q == FETCH) begin
      tx_data_q <= mem[char_index_q];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      len_q        <= '0;
      char_index_q <= '0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      char_index_q <= char_index_d;
      done_q       <= done_d;
    end
  end

  assign last_char = ({1'b0, char_index_q} == (len_q - LEN_ONE));

  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    char_index_d = char_index_q;
    done_d       = 1'b0;

    if (abort) begin
      state_d      = IDLE;
      char_index_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start && (msg_len != '0)) begin
            len_d        = (msg_len > DEPTH_L) ? DEPTH_L : msg_len;
            char_index_d = '0;
            state_d      = FETCH;
          end
        end
        FETCH: begin
          state_d = SEND;
        end
        SEND: begin
          if (tx_ready) begin
            if (!last_char) begin
              char_index_d = char_index_q + IDX_ONE;
              state_d      = FETCH;
            end else if (repeat_en) begin
              char_index_d = '0;
              state_d      = FETCH;
            end else begin
              char_index_d = '0;
              done_d       = 1'b1;
              state_d      = IDLE;
            end
          end
        end
        default: begin
          state_d      = IDLE;
          char_index_d = '0;
        end
      endcase
    end
  end

  assign tx_data    = tx_data_q;
  assign tx_valid   = (state_q == SEND);
  assign busy       = (state_q != IDLE);
  assign done       = done_q;
  assign char_index = char_index_q;

endmodule

// File: tb/tb_uart_message_streamer.sv
// Directed bench for uart_message_streamer: a cycle table for the basic message
// plus hand-written sequences for stalls, repeat, abort, length limits and reset.
module tb_uart_message_streamer;

  logic       clk;
  logic       rst_n;
  logic       wr_en;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;
  logic [4:0] msg_len;
  logic       start;
  logic       repeat_en;
  logic       abort;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       busy;
  logic       done;
  logic [3:0] char_index;

  uart_message_streamer #(.DEPTH(16), .DATA_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .msg_len(msg_len), .start(start), .repeat_en(repeat_en), .abort(abort),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .busy(busy), .done(done), .char_index(char_index)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       start;
    logic [4:0] msg_len;
    logic       tx_ready;
    logic [7:0] exp_data;
    logic       exp_valid;
    logic       exp_busy;
    logic       exp_done;
    logic [3:0] exp_idx;
  } vec_t;

  vec_t       tbl [8];
  logic [7:0] acc [$];
  int         done_cnt;
  int         excl_viol;
  int         total;
  int         passed;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Log handshakes of the current cycle, then advance to 1 time unit past the edge.
  task automatic cyc();
    if (tx_valid && tx_ready) acc.push_back(tx_data);
    @(posedge clk);
    #1;
    if (done) done_cnt++;
    if (done && busy) excl_viol++;
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    cyc();
    wr_en = 1'b0;
  endtask

  task automatic run_until_done(input int max_cyc, input string name);
    int  n;
    logic seen;
    n = 0; seen = 1'b0;
    while (!seen && n < max_cyc) begin
      cyc();
      n++;
      if (done) seen = 1'b1;
    end
    check(name, {31'd0, seen}, 32'd1);
  endtask

  // exp holds n characters right-justified, first character most significant.
  task automatic check_seq(input string name, input logic [127:0] exp, input int n);
    logic [7:0] got;
    logic [7:0] want;
    check($sformatf("%s_len", name), acc.size(), n);
    for (int k = 0; k < n; k++) begin
      got  = (k < acc.size()) ? acc[k] : 8'hxx;
      want = exp[8*(n-1-k) +: 8];
      check($sformatf("%s_char%0d", name, k), {24'd0, got}, {24'd0, want});
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    total = 0; passed = 0; done_cnt = 0; excl_viol = 0;
    rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    msg_len = '0; start = 1'b0; repeat_en = 1'b0; abort = 1'b0; tx_ready = 1'b0;

    // start, msg_len, tx_ready, exp_data, exp_valid, exp_busy, exp_done, exp_idx
    tbl[0] = '{1'b1, 5'd3, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 4'd0};
    tbl[1] = '{1'b0, 5'd3, 1'b1, 8'h48, 1'b1, 1'b1, 1'b0, 4'd0};
    tbl[2] = '{1'b0, 5'd3, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 4'd1};
    tbl[3] = '{1'b0, 5'd3, 1'b1, 8'h69, 1'b1, 1'b1, 1'b0, 4'd1};
    tbl[4] = '{1'b0, 5'd3, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 4'd2};
    tbl[5] = '{1'b0, 5'd3, 1'b1, 8'h21, 1'b1, 1'b1, 1'b0, 4'd2};
    tbl[6] = '{1'b0, 5'd3, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 4'd0};
    tbl[7] = '{1'b0, 5'd3, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 4'd0};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", {31'd0, tx_valid}, 0);
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_done", {31'd0, done}, 0);
    check("rst_idx", {28'd0, char_index}, 0);
    check("rst_data", {24'd0, tx_data}, 0);
    rst_n = 1'b1;
    cyc();

    // Test 1: "Hi!" with tx_ready held high, cycle by cycle
    wr(4'd0, 8'h48); wr(4'd1, 8'h69); wr(4'd2, 8'h21);
    for (int i = 0; i < 8; i++) begin
      start = tbl[i].start; msg_len = tbl[i].msg_len; tx_ready = tbl[i].tx_ready;
      cyc();
      check($sformatf("t1_v%0d_valid", i), {31'd0, tx_valid}, {31'd0, tbl[i].exp_valid});
      check($sformatf("t1_v%0d_busy", i), {31'd0, busy}, {31'd0, tbl[i].exp_busy});
      check($sformatf("t1_v%0d_done", i), {31'd0, done}, {31'd0, tbl[i].exp_done});
      if (tbl[i].exp_valid)
        check($sformatf("t1_v%0d_data", i), {24'd0, tx_data}, {24'd0, tbl[i].exp_data});
      if (tbl[i].exp_busy)
        check($sformatf("t1_v%0d_idx", i), {28'd0, char_index}, {28'd0, tbl[i].exp_idx});
    end
    start = 1'b0;

    // Test 2: stall on 'i' for 10 cycles
    acc.delete(); done_cnt = 0;
    msg_len = 5'd3; start = 1'b1; tx_ready = 1'b0;
    cyc();
    start = 1'b0;
    cyc();
    tx_ready = 1'b1;
    cyc();
    tx_ready = 1'b0;
    cyc();
    for (int i = 0; i < 10; i++) begin
      cyc();
      check($sformatf("t2_hold%0d_valid", i), {31'd0, tx_valid}, 1);
      check($sformatf("t2_hold%0d_data", i), {24'd0, tx_data}, 32'h69);
    end
    tx_ready = 1'b1;
    run_until_done(20, "t2_done_seen");
    check_seq("t2", "Hi!", 3);
    check("t2_done_cnt", done_cnt, 1);

    // Test 3: repeat "AB" for 7 handshakes, then drop repeat_en
    wr(4'd0, 8'h41); wr(4'd1, 8'h42);
    acc.delete(); done_cnt = 0;
    msg_len = 5'd2; repeat_en = 1'b1; start = 1'b1; tx_ready = 1'b1;
    cyc();
    start = 1'b0;
    for (int n = 0; n < 100 && acc.size() < 7; n++) cyc();
    repeat_en = 1'b0;
    run_until_done(20, "t3_done_seen");
    cyc(); cyc();
    check_seq("t3", "ABABABAB", 8);
    check("t3_done_cnt", done_cnt, 1);

    // Test 4: abort while stalled on index 1, then restart
    wr(4'd0, 8'h48); wr(4'd1, 8'h69); wr(4'd2, 8'h21);
    acc.delete(); done_cnt = 0;
    msg_len = 5'd3; start = 1'b1; tx_ready = 1'b1;
    cyc();
    start = 1'b0;
    cyc(); cyc();
    tx_ready = 1'b0;
    cyc();
    check("t4_pre_valid", {31'd0, tx_valid}, 1);
    check("t4_pre_idx", {28'd0, char_index}, 1);
    abort = 1'b1;
    cyc();
    abort = 1'b0;
    check("t4_abort_busy", {31'd0, busy}, 0);
    check("t4_abort_valid", {31'd0, tx_valid}, 0);
    check("t4_abort_idx", {28'd0, char_index}, 0);
    check("t4_abort_done", {31'd0, done}, 0);
    abort = 1'b1; start = 1'b1;
    cyc();
    abort = 1'b0; start = 1'b0;
    check("t4_abort_start_busy", {31'd0, busy}, 0);
    check("t4_abort_done_cnt", done_cnt, 0);
    acc.delete();
    start = 1'b1; tx_ready = 1'b1;
    cyc();
    start = 1'b0;
    run_until_done(20, "t4_restart_done");
    check_seq("t4_restart", "Hi!", 3);

    // Test 5a: zero-length start does nothing
    acc.delete(); done_cnt = 0;
    msg_len = 5'd0; start = 1'b1;
    cyc();
    start = 1'b0;
    cyc(); cyc();
    check("t5_zero_busy", {31'd0, busy}, 0);
    check("t5_zero_sent", acc.size(), 0);
    check("t5_zero_done", done_cnt, 0);

    // Test 5b: oversized length clamps to DEPTH; start while busy ignored
    for (int i = 0; i < 16; i++) wr(4'(i), 8'h40 + 8'(i));
    acc.delete(); done_cnt = 0;
    msg_len = 5'd19; start = 1'b1; tx_ready = 1'b1;
    cyc();
    start = 1'b0;
    repeat (5) cyc();
    msg_len = 5'd1; start = 1'b1;
    cyc();
    start = 1'b0;
    run_until_done(100, "t5_long_done");
    check("t5_long_len", acc.size(), 16);
    for (int k = 0; k < 16; k++)
      check($sformatf("t5_long_char%0d", k),
            {24'd0, (k < acc.size()) ? acc[k] : 8'hxx}, 32'h40 + k);
    check("t5_long_done_cnt", done_cnt, 1);

    // Test 5c: single-character message
    acc.delete(); done_cnt = 0;
    msg_len = 5'd1; start = 1'b1;
    cyc();
    start = 1'b0;
    run_until_done(20, "t5_one_done");
    check_seq("t5_one", 8'h40, 1);

    // Test 6: asynchronous reset mid-SEND, buffer survives
    acc.delete(); done_cnt = 0;
    msg_len = 5'd16; start = 1'b1; tx_ready = 1'b1;
    cyc();
    start = 1'b0;
    repeat (5) cyc();
    check("t6_pre_valid", {31'd0, tx_valid}, 1);
    check("t6_pre_idx", {28'd0, char_index}, 2);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_rst_valid", {31'd0, tx_valid}, 0);
    check("t6_rst_busy", {31'd0, busy}, 0);
    check("t6_rst_done", {31'd0, done}, 0);
    check("t6_rst_idx", {28'd0, char_index}, 0);
    check("t6_rst_data", {24'd0, tx_data}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    acc.delete(); done_cnt = 0;
    msg_len = 5'd3; start = 1'b1; tx_ready = 1'b1;
    cyc();
    start = 1'b0;
    run_until_done(20, "t6_resend_done");
    check_seq("t6_resend", "@AB", 3);

    check("busy_done_exclusive", excl_viol, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
